// File: rtl/ham_accum_pkg.sv
// Shared state encoding and slice constants for the multi-cycle Hamming-weight unit.
package ham_accum_pkg;

    localparam int unsigned SLICE_W = 8;
    localparam int unsigned POP_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ham_accum_ham8.sv
// HAM8: combinational population count of one 8-bit slice (weight 0..8).
module ham_accum_ham8
    import ham_accum_pkg::*;
(
    input  logic [SLICE_W-1:0] data,
    output logic [POP_W-1:0]   weight_c
);

    always_comb begin
        weight_c = '0;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            weight_c = weight_c + POP_W'(data[i]);
        end
    end

endmodule

// File: rtl/ham_accum.sv
// Multi-cycle Hamming-weight unit: one 8-bit slice per cycle, start/busy/done handshake.
module ham_accum
    import ham_accum_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CW         = 6,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             parity
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      acc_q, acc_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      count_d;
    logic               parity_d;
    logic               busy_d;
    logic               done_d;
    logic [POP_W-1:0]   weight_c;
    logic [CW-1:0]      acc_sum_c;
    logic               last_c;

    ham_accum_ham8 u_ham8 (
        .data     (shreg_q[SLICE_W-1:0]),
        .weight_c (weight_c)
    );

    assign acc_sum_c = acc_q + CW'(weight_c);

    // Last slice: either the final index, or (early exit) nothing left above the current slice.
    assign last_c = (idx_q == IW'(NSLICE - 1)) ||
                    (EARLY_EXIT && (shreg_q[WIDTH-1:SLICE_W] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count   <= '0;
            parity  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count   <= count_d;
            parity  <= parity_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Result is loaded on entry to DONE so count/parity are valid alongside the done pulse.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        count_d  = count;
        parity_d = parity;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = a;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_sum_c;
                shreg_d = shreg_q >> SLICE_W;
                idx_d   = idx_q + IW'(1);
                if (last_c) begin
                    state_d  = DONE;
                    count_d  = acc_sum_c;
                    parity_d = acc_sum_c[0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_ham_accum.sv
// Scoreboard bench: standard and early-exit builds share one stimulus stream, each with its own reference model.
module tb_ham_accum;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CW     = 6;
    localparam int unsigned NSLICE = WIDTH / 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;

    logic             busy   [2];
    logic             done   [2];
    logic [CW-1:0]    count  [2];
    logic             parity [2];

    ham_accum #(.WIDTH(WIDTH), .CW(CW), .EARLY_EXIT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a),
        .busy(busy[0]), .done(done[0]), .count(count[0]), .parity(parity[0])
    );

    ham_accum #(.WIDTH(WIDTH), .CW(CW), .EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a),
        .busy(busy[1]), .done(done[1]), .count(count[1]), .parity(parity[1])
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned   at;
        logic [CW-1:0] cnt;
        logic          par;
    } exp_t;

    exp_t          sb      [2][$];
    int unsigned   free_at [2];
    int unsigned   busy_lo [2];
    int unsigned   busy_hi [2];
    logic [CW-1:0] cur_cnt [2];
    logic          cur_par [2];

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // Cycles from the accepting edge to the cycle in which done is seen.
    function automatic int unsigned done_delay(input int inst, input logic [WIDTH-1:0] v);
        int unsigned hi;
        if (inst == 0) return NSLICE;
        hi = 0;
        for (int s = 0; s < int'(NSLICE); s++)
            if (v[8*s +: 8] != 8'h00) hi = s;
        return hi + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sb[i].delete();
            free_at[i] = 0;
            busy_lo[i] = 1;
            busy_hi[i] = 0;
            cur_cnt[i] = '0;
            cur_par[i] = 1'b0;
        end
    endtask

    // Present start/a for the next edge; the model decides per build whether it is accepted.
    task automatic drive(input logic s, input logic [WIDTH-1:0] v);
        int unsigned e, d;
        exp_t x;
        start = s;
        a     = v;
        if (s) begin
            e = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (e >= free_at[i]) begin
                    d     = done_delay(i, v);
                    x.at  = e + d;
                    x.cnt = CW'($countones(v));
                    x.par = ^v;
                    sb[i].push_back(x);
                    busy_lo[i] = e;
                    busy_hi[i] = e + d;
                    free_at[i] = e + d + 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, $urandom);
    endtask

    // Monitor: compares every output each cycle against the scoreboard/model.
    always @(negedge clk) begin
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                check("reset_busy", i, 32'(busy[i]), 32'd0);
                check("reset_done", i, 32'(done[i]), 32'd0);
                check("reset_count", i, 32'(count[i]), 32'd0);
                check("reset_parity", i, 32'(parity[i]), 32'd0);
            end else begin
                check("busy", i, 32'(busy[i]), 32'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
                if (sb[i].size() > 0 && sb[i][0].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_done inst=%0d cyc=%0d: got none expected done at %0d", i, cyc, sb[i][0].at);
                    void'(sb[i].pop_front());
                end
                if (done[i] === 1'b1) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done inst=%0d cyc=%0d: got done expected none", i, cyc);
                    end else begin
                        x = sb[i].pop_front();
                        check("done_cycle", i, x.at, cyc);
                        cur_cnt[i] = x.cnt;
                        cur_par[i] = x.par;
                    end
                end else begin
                    check("done_low", i, 32'(done[i]), 32'd0);
                end
                check("count", i, 32'(count[i]), 32'(cur_cnt[i]));
                check("parity", i, 32'(parity[i]), 32'(cur_par[i]));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] v;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(4);

        drive(1'b1, 32'hFFFF_FFFF);
        idle(7);

        drive(1'b1, 32'h8000_0001);
        for (int k = 0; k < 8; k++) drive(1'b1, 32'h0000_0007);
        idle(8);

        drive(1'b1, 32'h0F0F_0F0F);
        drive(1'b1, 32'h0000_0000);
        drive(1'b1, 32'h0000_0000);
        idle(6);

        // Abort mid-run: outputs must clear immediately, no done afterwards.
        drive(1'b1, 32'hFFFF_0000);
        idle(2);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("abort_busy", i, 32'(busy[i]), 32'd0);
            check("abort_count", i, 32'(count[i]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h0000_00FF);
        idle(7);

        drive(1'b1, 32'h0000_00A5);
        idle(6);
        drive(1'b1, 32'h0100_0000);
        idle(7);
        drive(1'b1, 32'h0000_0000);
        idle(6);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom >> $urandom_range(0, 31);
                2:       v = '0;
                default: v = 32'h1 << $urandom_range(0, 31);
            endcase
            drive(($urandom_range(0, 2) != 0), v);
        end
        idle(12);

        for (int i = 0; i < 2; i++) check("drain", i, sb[i].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
